// File: rtl/seg_scan_capture.sv
// seg_scan_capture: watches a multiplexed, active-low seven-segment scan bus
// and rebuilds the displayed six-digit value, decimal points, blank and
// bad-pattern flags. A frame is published once every digit has been
// captured at least once since the previous frame.

module seg_scan_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  seg_sel_in,
  input  logic [7:0]  seg_data_in,
  output logic [23:0] bcd_out,
  output logic [5:0]  dp_out,
  output logic [5:0]  blank_out,
  output logic [5:0]  bad_out,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        stale
);

  localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
  localparam logic [23:0] TIMEOUT_C = 24'(TIMEOUT);

  // Decode an active-low g..a pattern into {bad, blank, nibble}.
  function automatic logic [5:0] decode_seg(input logic [6:0] pat);
    logic [5:0] res;
    case (pat)
      7'h40:   res = {2'b00, 4'h0};
      7'h79:   res = {2'b00, 4'h1};
      7'h24:   res = {2'b00, 4'h2};
      7'h30:   res = {2'b00, 4'h3};
      7'h19:   res = {2'b00, 4'h4};
      7'h12:   res = {2'b00, 4'h5};
      7'h02:   res = {2'b00, 4'h6};
      7'h78:   res = {2'b00, 4'h7};
      7'h00:   res = {2'b00, 4'h8};
      7'h10:   res = {2'b00, 4'h9};
      7'h08:   res = {2'b00, 4'hA};
      7'h03:   res = {2'b00, 4'hB};
      7'h46:   res = {2'b00, 4'hC};
      7'h21:   res = {2'b00, 4'hD};
      7'h06:   res = {2'b00, 4'hE};
      7'h0E:   res = {2'b00, 4'hF};
      7'h7F:   res = {2'b01, 4'h0};
      default: res = {2'b10, 4'h0};
    endcase
    return res;
  endfunction

  // True when the active-low select names exactly one digit.
  function automatic logic single_select(input logic [5:0] sel);
    return ($countones(~sel) == 1);
  endfunction

  // Registered input copies and the previous select for stability detection
  logic [5:0]  sel_q_r;
  logic [5:0]  sel_prev_r;
  logic [7:0]  data_q_r;

  // Counters and staging state
  logic [7:0]  settle_cnt_r;
  logic [23:0] stale_cnt_r;
  logic [5:0]  mask_r;
  logic [23:0] stg_nib_r;
  logic [5:0]  stg_dp_r;
  logic [5:0]  stg_blank_r;
  logic [5:0]  stg_bad_r;

  // Output registers
  logic [23:0] bcd_r;
  logic [5:0]  dp_r;
  logic [5:0]  blank_r;
  logic [5:0]  bad_r;
  logic        frame_valid_r;
  logic        frame_changed_r;
  logic        stale_r;

  // Combinational helpers
  logic        sel_stable_s;
  logic [7:0]  settle_next_s;
  logic        capture_s;
  logic [5:0]  cap_bit_s;
  logic [5:0]  dec_s;
  logic        dp_lit_s;
  logic [23:0] stg_nib_next_s;
  logic [5:0]  stg_dp_next_s;
  logic [5:0]  stg_blank_next_s;
  logic [5:0]  stg_bad_next_s;
  logic [5:0]  mask_merged_s;
  logic        frame_done_s;
  logic        frame_diff_s;
  logic [23:0] stale_next_s;

  // Input register stage; the idle select is all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q_r    <= 6'h3F;
      sel_prev_r <= 6'h3F;
      data_q_r   <= 8'hFF;
    end else begin
      sel_q_r    <= seg_sel_in;
      sel_prev_r <= sel_q_r;
      data_q_r   <= seg_data_in;
    end
  end

  // Settle counting and capture decision: a capture fires on the single
  // cycle in which the counter steps onto SETTLE for a valid one-hot select
  always_comb begin
    sel_stable_s  = (sel_q_r == sel_prev_r);
    settle_next_s = settle_cnt_r;
    if (!sel_stable_s) begin
      settle_next_s = 8'd1;
    end else if (settle_cnt_r < SETTLE_C) begin
      settle_next_s = settle_cnt_r + 8'd1;
    end else begin
      settle_next_s = settle_cnt_r;
    end
    capture_s = sel_stable_s && (settle_cnt_r == (SETTLE_C - 8'd1)) &&
                single_select(sel_q_r);
    if (capture_s) begin
      cap_bit_s = ~sel_q_r;
    end else begin
      cap_bit_s = 6'h00;
    end
  end

  // Decode the current segment byte and merge it into the staging image
  always_comb begin
    dec_s            = decode_seg(data_q_r[6:0]);
    dp_lit_s         = ~data_q_r[7];
    stg_nib_next_s   = stg_nib_r;
    stg_dp_next_s    = stg_dp_r;
    stg_blank_next_s = stg_blank_r;
    stg_bad_next_s   = stg_bad_r;
    for (int k = 0; k < 6; k++) begin
      if (cap_bit_s[k]) begin
        stg_nib_next_s[23 - 4*k -: 4] = dec_s[3:0];
        stg_dp_next_s[k]              = dp_lit_s;
        stg_blank_next_s[k]           = dec_s[4];
        stg_bad_next_s[k]             = dec_s[5];
      end else begin
        stg_nib_next_s[23 - 4*k -: 4] = stg_nib_r[23 - 4*k -: 4];
      end
    end
    mask_merged_s = mask_r | cap_bit_s;
    frame_done_s  = capture_s && (mask_merged_s == 6'h3F);
    frame_diff_s  = (stg_nib_next_s != bcd_r) || (stg_dp_next_s != dp_r) ||
                    (stg_blank_next_s != blank_r);
  end

  // Next value of the saturating no-capture counter
  always_comb begin
    if (capture_s) begin
      stale_next_s = 24'd0;
    end else if (stale_cnt_r == TIMEOUT_C) begin
      stale_next_s = stale_cnt_r;
    end else begin
      stale_next_s = stale_cnt_r + 24'd1;
    end
  end

  // Settle counter, stale counter, capture mask and staging registers
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= 8'd0;
      stale_cnt_r  <= 24'd0;
      mask_r       <= 6'h00;
      stg_nib_r    <= 24'h000000;
      stg_dp_r     <= 6'h00;
      stg_blank_r  <= 6'h00;
      stg_bad_r    <= 6'h00;
    end else begin
      settle_cnt_r <= settle_next_s;
      stale_cnt_r  <= stale_next_s;
      stg_nib_r    <= stg_nib_next_s;
      stg_dp_r     <= stg_dp_next_s;
      stg_blank_r  <= stg_blank_next_s;
      stg_bad_r    <= stg_bad_next_s;
      if (frame_done_s) begin
        mask_r <= 6'h00;
      end else begin
        mask_r <= mask_merged_s;
      end
    end
  end

  // Publish a completed frame and generate the one-cycle strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_r           <= 24'h000000;
      dp_r            <= 6'h00;
      blank_r         <= 6'h00;
      bad_r           <= 6'h00;
      frame_valid_r   <= 1'b0;
      frame_changed_r <= 1'b0;
    end else if (frame_done_s) begin
      bcd_r           <= stg_nib_next_s;
      dp_r            <= stg_dp_next_s;
      blank_r         <= stg_blank_next_s;
      bad_r           <= stg_bad_next_s;
      frame_valid_r   <= 1'b1;
      frame_changed_r <= frame_diff_s;
    end else begin
      frame_valid_r   <= 1'b0;
      frame_changed_r <= 1'b0;
    end
  end

  // Stale flag: a completed frame always wins over a coincident timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      stale_r <= 1'b0;
    end else if (frame_done_s) begin
      stale_r <= 1'b0;
    end else if (stale_next_s == TIMEOUT_C) begin
      stale_r <= 1'b1;
    end else begin
      stale_r <= stale_r;
    end
  end

  assign bcd_out       = bcd_r;
  assign dp_out        = dp_r;
  assign blank_out     = blank_r;
  assign bad_out       = bad_r;
  assign frame_valid   = frame_valid_r;
  assign frame_changed = frame_changed_r;
  assign stale         = stale_r;

endmodule
